// File: rtl/uop_pkg.sv
// Shared definitions for the micro-op buffer: sizing, the packed entry
// layout used by both the writer and uop_fetch, and the writer FSM states.
package uop_pkg;

    localparam int UOP_BUF_SIZE           = 128;
    localparam int MAX_PREDICT_DEPTH      = 3;
    localparam int MAX_PREDICT_DEPTH_BITS = $clog2(MAX_PREDICT_DEPTH);
    localparam int UOP_BUF_WIDTH          = 64 + MAX_PREDICT_DEPTH_BITS * 2;
    localparam logic [31:0] PAD_INSTR     = 32'h0000_0000;

    localparam int UOP_ADDR_BITS  = $clog2(UOP_BUF_SIZE);
    localparam int UOP_COUNT_BITS = UOP_ADDR_BITS + 1;
    localparam logic [UOP_COUNT_BITS-1:0] UOP_COUNT_FULL = UOP_COUNT_BITS'(UOP_BUF_SIZE);

    typedef logic [MAX_PREDICT_DEPTH_BITS-1:0] branch_tag_t;

    // First member lands in the MSBs, so instruction_1 occupies bits [31:0].
    typedef struct packed {
        branch_tag_t branch_tag_2;
        branch_tag_t branch_tag_1;
        logic [31:0] instruction_2;
        logic [31:0] instruction_1;
    } uop_entry_t;

    typedef enum logic {
        IDLE,
        HALF
    } writer_state_t;

    function automatic uop_entry_t pack_entry(
        input logic [31:0] instruction_1,
        input branch_tag_t branch_tag_1,
        input logic [31:0] instruction_2,
        input branch_tag_t branch_tag_2
    );
        uop_entry_t e;
        e.instruction_1 = instruction_1;
        e.branch_tag_1  = branch_tag_1;
        e.instruction_2 = instruction_2;
        e.branch_tag_2  = branch_tag_2;
        return e;
    endfunction

endpackage

// File: rtl/uop_ram.sv
// Micro-op storage: one synchronous write port, one asynchronous read port.
// Reset zeroes every entry so unwritten slots read back as 0.
module uop_ram #(
    parameter int DEPTH     = 128,
    parameter int WIDTH     = 68,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write_en,
    input  logic [ADDR_BITS-1:0] write_addr,
    input  logic [WIDTH-1:0]     write_data,
    input  logic [ADDR_BITS-1:0] read_addr,
    output logic [WIDTH-1:0]     read_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array is reset because readers rely on unwritten entries being 0;
    // this rules out block-RAM inference, which is acceptable at this depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    // Same-cycle read of the address being written sees the old content.
    assign read_data = mem[read_addr];

endmodule

// File: rtl/uop_buffer_writer.sv
// Packs a serial instruction stream into two-instruction micro-op entries and
// writes them sequentially into the buffer that uop_fetch reads.
module uop_buffer_writer
    import uop_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [31:0]                       in_instruction,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] in_branch_tag,
    input  logic                              in_last,
    input  logic [UOP_ADDR_BITS-1:0]          uop_addr,
    output logic [UOP_BUF_WIDTH-1:0]          uop,
    output logic [UOP_COUNT_BITS-1:0]         fill_count,
    output logic                              full
);

    writer_state_t state;
    writer_state_t next_state;

    logic [31:0]  pending_instruction;
    branch_tag_t  pending_tag;
    logic         load_pending;
    logic         write_en;
    uop_entry_t   write_entry;
    uop_entry_t   read_entry;
    logic         transfer;

    assign full     = (fill_count == UOP_COUNT_FULL);
    assign in_ready = !full && !reset && !clear;
    assign transfer = in_valid && in_ready;

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        next_state   = state;
        load_pending = 1'b0;
        write_en     = 1'b0;
        write_entry  = '0;
        unique case (state)
            IDLE: begin
                if (transfer) begin
                    if (in_last) begin
                        write_en    = 1'b1;
                        write_entry = pack_entry(in_instruction, in_branch_tag, PAD_INSTR, '0);
                    end else begin
                        load_pending = 1'b1;
                        next_state   = HALF;
                    end
                end
            end
            HALF: begin
                if (transfer) begin
                    write_en    = 1'b1;
                    write_entry = pack_entry(pending_instruction, pending_tag,
                                             in_instruction, in_branch_tag);
                    next_state  = IDLE;
                end else if (in_last && !in_valid && in_ready) begin
                    // End of stream with an odd count: pad the second slot.
                    write_en    = 1'b1;
                    write_entry = pack_entry(pending_instruction, pending_tag, PAD_INSTR, '0);
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state               <= IDLE;
            fill_count          <= '0;
            pending_instruction <= '0;
            pending_tag         <= '0;
        end else begin
            state <= next_state;
            if (write_en) begin
                fill_count <= fill_count + UOP_COUNT_BITS'(1);
            end
            if (load_pending) begin
                pending_instruction <= in_instruction;
                pending_tag         <= in_branch_tag;
            end
        end
    end

    // fill_count doubles as the write pointer; it never writes once full.
    uop_ram #(
        .DEPTH     (UOP_BUF_SIZE),
        .WIDTH     (UOP_BUF_WIDTH),
        .ADDR_BITS (UOP_ADDR_BITS)
    ) u_ram (
        .clk        (clk),
        .reset      (reset),
        .write_en   (write_en),
        .write_addr (fill_count[UOP_ADDR_BITS-1:0]),
        .write_data (write_entry),
        .read_addr  (uop_addr),
        .read_data  (read_entry)
    );

    assign uop = read_entry;

endmodule

// File: tb/tb_uop_buffer_writer.sv
// Self-checking bench for uop_buffer_writer: directed vector table, hand-written
// corner sequences and a randomized stream checked against a behavioural model.
module tb_uop_buffer_writer;
    import uop_pkg::*;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         clear;
    logic                         in_valid;
    logic                         in_ready;
    logic [31:0]                  in_instruction;
    logic [1:0]                   in_branch_tag;
    logic                         in_last;
    logic [6:0]                   uop_addr;
    logic [67:0]                  uop;
    logic [7:0]                   fill_count;
    logic                         full;

    int checks = 0;
    int errors = 0;

    uop_buffer_writer dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instruction (in_instruction),
        .in_branch_tag  (in_branch_tag),
        .in_last        (in_last),
        .uop_addr       (uop_addr),
        .uop            (uop),
        .fill_count     (fill_count),
        .full           (full)
    );

    always #5 clk = ~clk;

    // Behavioural model: the buffer as an array, a count, and an optional
    // half-finished pair.
    logic [67:0] m_mem [128];
    int          m_count;
    bit          m_has_pend;
    logic [31:0] m_pend_instr;
    logic [1:0]  m_pend_tag;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic model_write(input logic [67:0] e);
        m_mem[m_count] = e;
        m_count++;
    endtask

    // Applies the buffer rules to the inputs currently driven, as of the next edge.
    task automatic model_edge();
        bit ready;
        ready = (m_count < 128) && !reset && !clear;
        if (reset) begin
            for (int i = 0; i < 128; i++) m_mem[i] = '0;
            m_count    = 0;
            m_has_pend = 0;
        end else if (clear) begin
            m_count    = 0;
            m_has_pend = 0;
        end else if (in_valid && ready) begin
            if (m_has_pend) begin
                model_write({in_branch_tag, m_pend_tag, in_instruction, m_pend_instr});
                m_has_pend = 0;
            end else if (in_last) begin
                model_write({2'd0, in_branch_tag, PAD_INSTR, in_instruction});
            end else begin
                m_has_pend   = 1;
                m_pend_instr = in_instruction;
                m_pend_tag   = in_branch_tag;
            end
        end else if (!in_valid && in_last && m_has_pend && ready) begin
            model_write({2'd0, m_pend_tag, PAD_INSTR, m_pend_instr});
            m_has_pend = 0;
        end
    endtask

    task automatic idle_inputs();
        reset          = 1'b0;
        clear          = 1'b0;
        in_valid       = 1'b0;
        in_last        = 1'b0;
        in_instruction = '0;
        in_branch_tag  = '0;
    endtask

    // One clock: update the model, take the edge, then return inputs to idle.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".fill_count"}, 128'(fill_count), 128'(m_count));
        check({tag, ".full"},       128'(full),       128'(m_count == 128));
        check({tag, ".in_ready"},   128'(in_ready),   128'(m_count < 128));
        check({tag, ".uop"},        128'(uop),        128'(m_mem[uop_addr]));
    endtask

    typedef struct {
        logic        valid;
        logic        last;
        logic        clr;
        logic [31:0] instr;
        logic [1:0]  tag;
        logic [6:0]  addr;
        int          exp_count;
        logic [67:0] exp_uop;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [67:0] old_entry;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'hAAAA0001, 2'd1, 7'd0, 0, 68'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 32'hBBBB0002, 2'd2, 7'd0, 1, {2'd2, 2'd1, 32'hBBBB0002, 32'hAAAA0001}};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h12345678, 2'd3, 7'd1, 2, {2'd0, 2'd3, 32'h0, 32'h12345678}};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'hCAFE0000, 2'd1, 7'd2, 2, 68'h0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0,        2'd0, 7'd2, 3, {2'd0, 2'd1, 32'h0, 32'hCAFE0000}};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h11111111, 2'd2, 7'd3, 3, 68'h0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h22222222, 2'd0, 7'd0, 0, {2'd2, 2'd1, 32'hBBBB0002, 32'hAAAA0001}};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h33333333, 2'd1, 7'd0, 1, {2'd0, 2'd1, 32'h0, 32'h33333333}};

        idle_inputs();
        uop_addr = '0;
        for (int i = 0; i < 128; i++) m_mem[i] = 'x;
        m_count = 0;
        m_has_pend = 0;

        // Reset state, including in_ready dropping while reset is asserted.
        reset = 1'b1;
        #1;
        check("ready_during_reset", 128'(in_ready), 128'(0));
        tick();
        check("reset.fill_count", 128'(fill_count), 128'(0));
        check("reset.full",       128'(full),       128'(0));
        check("reset.in_ready",   128'(in_ready),   128'(1));
        check("reset.uop",        128'(uop),        128'(0));

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            in_valid       = vecs[i].valid;
            in_last        = vecs[i].last;
            clear          = vecs[i].clr;
            in_instruction = vecs[i].instr;
            in_branch_tag  = vecs[i].tag;
            uop_addr       = vecs[i].addr;
            tick();
            check($sformatf("vec%0d.fill_count", i), 128'(fill_count), 128'(vecs[i].exp_count));
            check($sformatf("vec%0d.uop", i),        128'(uop),        128'(vecs[i].exp_uop));
            check_model($sformatf("vec%0d.model", i));
        end

        // Read and write of the same address in one cycle.
        reset = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_last = 1'b1;
            in_instruction = 32'h1000_0000 + 32'(k);
            in_branch_tag  = 2'(k);
            tick();
        end
        clear = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_last = 1'b1;
            in_instruction = 32'h2000_0000 + 32'(k);
            in_branch_tag  = 2'd1;
            tick();
        end
        uop_addr = 7'd3;
        in_valid = 1'b1; in_last = 1'b1;
        in_instruction = 32'hDEADBEEF; in_branch_tag = 2'd2;
        #1;
        check("rw_same_cycle_old", 128'(uop), 128'({2'd0, 2'd3, 32'h0, 32'h10000003}));
        tick();
        check("rw_next_cycle_new", 128'(uop), 128'({2'd0, 2'd2, 32'h0, 32'hDEADBEEF}));
        check_model("rw");

        // Fill to capacity: 256 instructions, last entry written from HALF.
        reset = 1'b1;
        tick();
        for (int k = 0; k < 256; k++) begin
            in_valid = 1'b1; in_last = 1'b0;
            in_instruction = $urandom;
            in_branch_tag  = 2'($urandom_range(0, 3));
            uop_addr       = 7'($urandom_range(0, 127));
            tick();
            check_model($sformatf("fill%0d", k));
        end
        check("full.fill_count", 128'(fill_count), 128'(128));
        check("full.full",       128'(full),       128'(1));
        check("full.in_ready",   128'(in_ready),   128'(0));
        uop_addr = 7'd0;
        old_entry = m_mem[0];
        in_valid = 1'b1; in_instruction = 32'hFFFF_FFFF; in_branch_tag = 2'd3;
        tick();
        check("overflow.fill_count", 128'(fill_count), 128'(128));
        check("overflow.entry0",     128'(uop),        128'(old_entry));
        in_last = 1'b1;
        tick();
        check("overflow_flush.fill_count", 128'(fill_count), 128'(128));

        // Reset arriving mid-pair drops the pending instruction.
        reset = 1'b1;
        tick();
        uop_addr = 7'd0;
        in_valid = 1'b1; in_instruction = 32'h5555_5555; in_branch_tag = 2'd2;
        tick();
        reset = 1'b1; in_valid = 1'b1; in_instruction = 32'h6666_6666;
        #1;
        check("midpair.ready_in_reset", 128'(in_ready), 128'(0));
        tick();
        check("midpair.fill_count", 128'(fill_count), 128'(0));
        in_valid = 1'b1; in_last = 1'b1; in_instruction = 32'h7777_7777; in_branch_tag = 2'd1;
        tick();
        check("midpair.entry0", 128'(uop), 128'({2'd0, 2'd1, 32'h0, 32'h77777777}));
        check_model("midpair");

        // Randomized stream against the model.
        reset = 1'b1;
        tick();
        for (int k = 0; k < 600; k++) begin
            in_valid       = ($urandom_range(0, 3) != 0);
            in_last        = ($urandom_range(0, 3) == 0);
            clear          = ($urandom_range(0, 60) == 0);
            reset          = ($urandom_range(0, 150) == 0);
            in_instruction = $urandom;
            in_branch_tag  = 2'($urandom_range(0, 3));
            uop_addr       = 7'($urandom_range(0, 127));
            tick();
            check_model($sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
